instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 o_imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-006 o_imem_addr  out  32  word-aligned fetch address, equal to the PC register.
REQ-007 i_imem_ack  in  1  one-cycle pulse: i_imem_data is valid for the outstanding request.
REQ-008 i_imem_data  in  32  fetched instruction word.
REQ-009 i_stall  in  1  decode cannot accept; o_instr, o_pc and o_ce hold.
REQ-010 i_flush  in  1  redirect fetch to i_branch_pc; has priority over i_stall.
REQ-011 i_branch_pc  in  32  redirect target.
REQ-012 o_instr  out  32  instruction presented to decode (decode i_instr).
REQ-013 o_pc  out  32  PC of o_instr (decode i_pc).
REQ-014 o_ce  out  1  o_instr/o_pc valid (decode i_ce).

Function
REQ-015 SHALL use FSM states IDLE, FETCH, DROP and HOLD.
- IDLE: entered from reset; goes to FETCH on the first clock after rst falls.
REQ-016 FETCH SHALL assert o_imem_req with o_imem_addr = PC, keeping both stable until i_imem_ack.
REQ-017 Ack in FETCH with i_stall=0 SHALL, next edge: o_instr <= i_imem_data, o_pc <= PC, o_ce <= 1, PC <= PC+4 (mod 2^32), stay in FETCH.
- Resulting throughput: one instruction per cycle with a 1-cycle-latency memory.
REQ-018 Ack in FETCH with i_stall=1 SHALL capture data and address into a one-entry skid buffer, set PC <= PC+4, drop o_imem_req and enter HOLD.
- o_instr, o_pc and o_ce are unchanged.
REQ-019 HOLD with i_stall=0 SHALL move the skid buffer to the outputs with o_ce=1, then return to FETCH.
REQ-020 With no new ack, o_ce SHALL fall to 0 after one accepted cycle and o_instr SHALL become NOP_INSTR.
- Each instruction is presented exactly once; no duplication.
REQ-021 i_flush SHALL take effect on the next edge:
- PC <= i_branch_pc; o_ce <= 0; o_instr <= NOP_INSTR; skid buffer invalidated.
REQ-022 If a request is outstanding without an ack in the flush cycle, the block SHALL enter DROP.
- DROP deasserts o_imem_req, discards the next ack, then enters FETCH at the new PC.
REQ-023 Flush coinciding with ack SHALL discard that data and go directly to FETCH at i_branch_pc.
REQ-024 Flush while in DROP SHALL update PC and remain in DROP.
REQ-025 At most one memory request SHALL be outstanding at any time.

Reset
REQ-026 While rst=1, the block SHALL hold:
- state=IDLE, PC=RESET_PC, o_imem_req=0, o_ce=0, o_instr=NOP_INSTR, o_pc=RESET_PC, skid empty, any outstanding request abandoned.
REQ-027 An ack arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-028 With IF_MISALIGN_TRAP_EN defined, a flush whose i_branch_pc[1:0] != 0 SHALL:
- assert output o_misaligned (1 bit) for one cycle;
- force PC to {i_branch_pc[31:2],2'b00}.
REQ-029 Without IF_MISALIGN_TRAP_EN, o_misaligned SHALL not exist and i_branch_pc[1:0] SHALL be ignored (treated as 00).

Structure
REQ-030 The shared pipeline package SHALL hold the NOP encoding, the XLEN=32 constant and the FSM state typedef.
REQ-031 The skid buffer SHALL be a sub-module named fetch_skid_buf (data, pc, valid; load/unload/clear).

Verification
REQ-032 Reset release, RESET_PC=0, ack every cycle with data = 0x00218333, 0x18431663, 0x00840393 -> o_pc = 0, 4, 8 on consecutive cycles with o_ce=1.
REQ-033 i_stall=1 for 3 cycles while ack returns 0x00828467 at PC 0xC -> outputs frozen, req low, after release o_instr=0x00828467, o_pc=0xC.
REQ-034 Flush to 0x100 with request outstanding, ack 2 cycles later returning 0xDEADBEEF -> data discarded, next o_imem_addr=0x100, o_ce=0 until then.
REQ-035 Flush to 0x200 coincident with ack -> no DROP, o_imem_addr=0x200 next cycle, acked data never reaches o_instr.
REQ-036 rst asserted mid-request with ack pending -> o_ce=0, o_instr=0x00000013, PC=RESET_PC, late ack ignored.
REQ-037 (IF_MISALIGN_TRAP_EN) Flush to 0x102 -> o_misaligned pulses once, o_imem_addr=0x100.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared pipeline definitions for the fetch stage and its neighbours:
//   XLEN          - datapath width (32)
//   NOP_ENC       - bubble instruction encoding (addi x0,x0,0)
//   fetch_state_t - fetch FSM state type
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry skid buffer holding an instruction that returned from memory while
// decode was stalled.
//   clk, rst           - clock, asynchronous active-high reset
//   load               - capture load_data/load_pc, mark valid
//   unload             - entry consumed, mark empty
//   clear              - invalidate (flush); wins over load/unload
//   load_data, load_pc - instruction word and its address
//   data, pc, valid    - buffered entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] data,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: issues one read at a time to instruction memory and
// presents each returned word to decode exactly once, with stall and flush.
// Optional feature macro: IF_MISALIGN_TRAP_EN (adds o_misaligned).
//   RESET_PC      - first fetch address after reset
//   NOP_INSTR     - bubble presented when no instruction is valid
//   clk, rst      - clock, asynchronous active-high reset
//   o_imem_req    - read request, held until i_imem_ack
//   o_imem_addr   - fetch address (the PC register)
//   i_imem_ack    - one-cycle pulse, i_imem_data valid
//   i_imem_data   - fetched instruction word
//   i_stall       - decode cannot accept; outputs hold
//   i_flush       - redirect to i_branch_pc (priority over i_stall)
//   i_branch_pc   - redirect target (low two bits treated as zero)
//   o_misaligned  - one-cycle pulse on a misaligned redirect (macro only)
//   o_instr, o_pc - instruction and its address to decode
//   o_ce          - o_instr/o_pc valid
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_data,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_branch_pc,
`ifdef IF_MISALIGN_TRAP_EN
    output logic            o_misaligned,
`endif
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_ce
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] instr_nxt, opc_nxt;
    logic            ce_nxt;
    logic            skid_load, skid_unload, skid_clear;
    logic [XLEN-1:0] skid_data, skid_pc;
    logic            skid_valid;
    logic [XLEN-1:0] branch_aligned;

    assign branch_aligned = {i_branch_pc[XLEN-1:2], 2'b00};
    assign o_imem_req     = (state == FETCH);
    assign o_imem_addr    = pc;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_data (i_imem_data),
        .load_pc   (pc),
        .data      (skid_data),
        .pc        (skid_pc),
        .valid     (skid_valid)
    );

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = o_instr;
        opc_nxt     = o_pc;
        ce_nxt      = o_ce;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        case (state)
            IDLE: begin
                // any ack seen here belongs to a pre-reset request
                state_nxt = FETCH;
            end
            FETCH: begin
                if (i_imem_ack) begin
                    pc_nxt = pc + 32'd4;
                    if (i_stall) begin
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        instr_nxt = i_imem_data;
                        opc_nxt   = pc;
                        ce_nxt    = 1'b1;
                    end
                end else if (!i_stall) begin
                    // current presentation accepted, nothing new behind it
                    ce_nxt    = 1'b0;
                    instr_nxt = NOP_INSTR;
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    instr_nxt   = skid_data;
                    opc_nxt     = skid_pc;
                    ce_nxt      = skid_valid;
                    skid_unload = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            DROP: begin
                if (i_imem_ack)
                    state_nxt = FETCH;
                if (!i_stall) begin
                    ce_nxt    = 1'b0;
                    instr_nxt = NOP_INSTR;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (i_flush) begin
            pc_nxt      = branch_aligned;
            ce_nxt      = 1'b0;
            instr_nxt   = NOP_INSTR;
            skid_clear  = 1'b1;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            // an unanswered request must be drained before refetching; an ack
            // landing in the flush cycle itself closes it out (also from DROP)
            if ((state == FETCH || state == DROP) && !i_imem_ack)
                state_nxt = DROP;
            else
                state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            o_instr <= NOP_INSTR;
            o_pc    <= RESET_PC;
            o_ce    <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            o_instr <= instr_nxt;
            o_pc    <= opc_nxt;
            o_ce    <= ce_nxt;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_misaligned <= 1'b0;
        else
            o_misaligned <= i_flush && (i_branch_pc[1:0] != 2'b00);
    end
`else
    logic unused_branch_lsbs;
    assign unused_branch_lsbs = ^i_branch_pc[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_branch_pc;
`ifdef IF_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_ce;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .o_imem_req  (o_imem_req),
        .o_imem_addr (o_imem_addr),
        .i_imem_ack  (i_imem_ack),
        .i_imem_data (i_imem_data),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_branch_pc (i_branch_pc),
`ifdef IF_MISALIGN_TRAP_EN
        .o_misaligned(o_misaligned),
`endif
        .o_instr     (o_instr),
        .o_pc        (o_pc),
        .o_ce        (o_ce)
    );

    // memory contents used by the random phase: a fixed function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ce, input logic [31:0] pc,
                             input logic [31:0] instr);
        check({tag, ".ce"}, 32'(o_ce), 32'(ce));
        check({tag, ".pc"}, o_pc, pc);
        check({tag, ".instr"}, o_instr, instr);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, 32'(o_imem_req), 32'(req));
        check({tag, ".addr"}, o_imem_addr, addr);
    endtask

    logic [31:0] prog [3];

    // random-phase model state
    logic        outstanding, flushed_out, redirect_pending, flush_prev;
    logic [31:0] out_addr, redirect_addr, exp_pc;
    int unsigned delay, consumed;

    initial begin
        prog[0] = 32'h0021_8333;
        prog[1] = 32'h1843_1663;
        prog[2] = 32'h0084_0393;

        // reset with a junk ack pending
        rst = 1'b1; i_imem_ack = 1'b1; i_imem_data = 32'hBAD0_BAD0;
        i_stall = 1'b0; i_flush = 1'b0; i_branch_pc = '0;
        @(negedge clk);
        check_out("reset", 1'b0, RST_PC, NOP);
        check_req("reset", 1'b0, RST_PC);

        // ack in the first cycle after release is ignored
        rst = 1'b0;
        @(negedge clk);
        check_out("post_rst", 1'b0, RST_PC, NOP);
        check_req("post_rst", 1'b1, RST_PC);

        // back-to-back acks: one instruction per cycle
        for (int unsigned i = 0; i < 3; i++) begin
            i_imem_ack = 1'b1; i_imem_data = prog[i];
            @(negedge clk);
            check_out("stream", 1'b1, 32'(4 * i), prog[i]);
        end
        check_req("stream_next", 1'b1, 32'h0000_000C);

        // stall for 3 cycles while the 0xC fetch returns
        i_stall = 1'b1; i_imem_ack = 1'b1; i_imem_data = 32'h0082_8467;
        @(negedge clk);
        i_imem_ack = 1'b0; i_imem_data = 32'hFFFF_FFFF;
        check_out("stall0", 1'b1, 32'h8, prog[2]);
        check("stall0.req", 32'(o_imem_req), 32'd0);
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clk);
            check_out("stall_hold", 1'b1, 32'h8, prog[2]);
            check("stall_hold.req", 32'(o_imem_req), 32'd0);
        end
        i_stall = 1'b0;
        @(negedge clk);
        check_out("skid_out", 1'b1, 32'h0000_000C, 32'h0082_8467);
        check_req("skid_out", 1'b1, 32'h0000_0010);
        @(negedge clk);
        check("bubble.ce", 32'(o_ce), 32'd0);
        check("bubble.instr", o_instr, NOP);

        // flush with request outstanding: late ack dropped
        i_flush = 1'b1; i_branch_pc = 32'h0000_0100;
        @(negedge clk);
        i_flush = 1'b0;
        check("drop0.req", 32'(o_imem_req), 32'd0);
        check("drop0.ce", 32'(o_ce), 32'd0);
        check("drop0.instr", o_instr, NOP);
        @(negedge clk);
        check("drop1.req", 32'(o_imem_req), 32'd0);
        check("drop1.ce", 32'(o_ce), 32'd0);
        i_imem_ack = 1'b1; i_imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        i_imem_ack = 1'b0;
        check_req("after_drop", 1'b1, 32'h0000_0100);
        check("after_drop.ce", 32'(o_ce), 32'd0);
        check("after_drop.instr", o_instr, NOP);

        // flush coincident with ack: straight to the new target
        i_imem_ack = 1'b1; i_imem_data = 32'h1111_1111;
        i_flush = 1'b1; i_branch_pc = 32'h0000_0200;
        @(negedge clk);
        i_flush = 1'b0;
        check_req("flush_ack", 1'b1, 32'h0000_0200);
        check("flush_ack.ce", 32'(o_ce), 32'd0);
        check("flush_ack.instr", o_instr, NOP);
        i_imem_data = 32'h2222_2222;
        @(negedge clk);
        i_imem_ack = 1'b0;
        check_out("flush_ack_next", 1'b1, 32'h0000_0200, 32'h2222_2222);
        check_req("flush_ack_next", 1'b1, 32'h0000_0204);

        // asynchronous reset mid-request, then a late ack
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, RST_PC, NOP);
        check_req("async_rst", 1'b0, RST_PC);
        @(negedge clk);
        rst = 1'b0; i_imem_ack = 1'b1; i_imem_data = 32'hBADB_AD00;
        @(negedge clk);
        i_imem_ack = 1'b0;
        check_out("late_ack", 1'b0, RST_PC, NOP);
        check_req("late_ack", 1'b1, RST_PC);
        @(negedge clk);
        check("late_ack2.ce", 32'(o_ce), 32'd0);

`ifdef IF_MISALIGN_TRAP_EN
        i_flush = 1'b1; i_branch_pc = 32'h0000_0102;
        @(negedge clk);
        i_flush = 1'b0;
        check("misalign.pulse", 32'(o_misaligned), 32'd1);
        check("misalign.addr", o_imem_addr, 32'h0000_0100);
        @(negedge clk);
        check("misalign.once", 32'(o_misaligned), 32'd0);
        i_imem_ack = 1'b1;
        @(negedge clk);
        i_imem_ack = 1'b0;
`endif

        // random phase: memory with 0..2 cycle latency, random stall/flush
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outstanding = 1'b0; flushed_out = 1'b0; flush_prev = 1'b0;
        redirect_pending = 1'b1; redirect_addr = RST_PC; exp_pc = RST_PC;
        out_addr = '0; delay = 0; consumed = 0;
        @(negedge clk);
        for (int unsigned k = 0; k < 3000; k++) begin
            if (flush_prev) check("rnd.flush_ce", 32'(o_ce), 32'd0);
            if (!o_ce) check("rnd.idle_nop", o_instr, NOP);
            if (flushed_out) check("rnd.drop_req", 32'(o_imem_req), 32'd0);
            if (o_imem_req) begin
                check("rnd.addr_align", 32'(o_imem_addr[1:0]), 32'd0);
                if (outstanding) begin
                    check("rnd.addr_stable", o_imem_addr, out_addr);
                end else begin
                    outstanding = 1'b1;
                    out_addr    = o_imem_addr;
                    delay       = $urandom_range(0, 2);
                    if (redirect_pending) begin
                        check("rnd.redirect", o_imem_addr, redirect_addr);
                        redirect_pending = 1'b0;
                    end
                end
            end

            i_imem_ack  = outstanding && (delay == 0);
            i_imem_data = i_imem_ack ? mem_word(out_addr) : $urandom;
            i_stall     = ($urandom_range(0, 99) < 30);
            i_flush     = ($urandom_range(0, 99) < 6);
            i_branch_pc = $urandom;

            if (i_flush) begin
                exp_pc           = i_branch_pc & ~32'h3;
                redirect_pending = 1'b1;
                redirect_addr    = exp_pc;
                flushed_out      = outstanding && !i_imem_ack;
            end else if (o_ce && !i_stall) begin
                consumed++;
                check("rnd.pc", o_pc, exp_pc);
                check("rnd.instr", o_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            flush_prev = i_flush;
            if (i_imem_ack) begin
                outstanding = 1'b0;
                flushed_out = 1'b0;
            end else if (outstanding) begin
                delay--;
            end
            @(negedge clk);
        end
        i_imem_ack = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        check("rnd.progress", 32'(consumed > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
